audio_mix_stage: RTL and testbench

AUDIO_MIX_STAGE -- requirements
Module: audio_mix_stage

---
 rtl/audio_mix_if.sv | 26 ++
 rtl/audio_mix_stage.sv | 90 +++++++++
 tb/tb_audio_mix_stage.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_mix_if.sv
// audio_mix_if: frame strobe, source/gain inputs and mixed-sample outputs of the mixer
interface audio_mix_if;
  logic        sample_stb;
  logic [79:0] in_l;
  logic [79:0] in_r;
  logic [7:0]  vol1;
  logic [7:0]  vol2;
  logic [7:0]  vol3;
  logic [7:0]  vol4;
  logic [7:0]  vol5;
  logic        swap_channels;
  logic [15:0] out_l;
  logic [15:0] out_r;
  logic        out_valid;
  logic        audio_overflow;
  logic        busy;
  logic        stb_missed;
  modport master (
    output sample_stb, in_l, in_r, vol1, vol2, vol3, vol4, vol5, swap_channels,
    input  out_l, out_r, out_valid, audio_overflow, busy, stb_missed
  );
  modport slave (
    input  sample_stb, in_l, in_r, vol1, vol2, vol3, vol4, vol5, swap_channels,
    output out_l, out_r, out_valid, audio_overflow, busy, stb_missed
  );
endinterface

// File: rtl/audio_mix_stage.sv
// audio_mix_stage: five-source stereo mixer, one shared 17x17 MAC per cycle, saturating output
module audio_mix_stage #(
  parameter int GAIN_SHIFT = 7
) (
  input logic       clk,
  input logic       rst,
  audio_mix_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MAC, SAT, DONE} state_t;
  state_t             state;
  logic [3:0]         idx;
  logic [79:0]        snap_l;
  logic [79:0]        snap_r;
  logic [39:0]        snap_vol;
  logic               snap_swap;
  logic signed [26:0] acc_l;
  logic signed [26:0] acc_r;
  logic               sat_l;
  logic               sat_r;
  logic [2:0]         src;
  logic signed [15:0] sample;
  logic [7:0]         vol;
  logic signed [26:0] prod;
  logic [16:0]        cl;
  logic [16:0]        cr;
  // {saturated, value} after the floor shift and 16-bit clamp
  function automatic logic [16:0] clamp(input logic signed [26:0] a);
    logic signed [26:0] s;
    s = a >>> GAIN_SHIFT;
    return s > 27'sd32767 ? {1'b1, 16'h7fff} : s < -27'sd32768 ? {1'b1, 16'h8000} : {1'b0, s[15:0]};
  endfunction
  assign src    = idx < 4'd5 ? idx[2:0] : 3'(idx - 4'd5);
  assign sample = idx < 4'd5 ? snap_l[{src, 4'd0} +: 16] : snap_r[{src, 4'd0} +: 16];
  assign vol    = snap_vol[{src, 3'd0} +: 8];
  assign prod   = 27'(sample) * 27'($signed({1'b0, vol}));
  assign cl     = clamp(acc_l);
  assign cr     = clamp(acc_r);
  assign bus.audio_overflow = sat_l | sat_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      acc_l          <= '0;
      acc_r          <= '0;
      sat_l          <= 1'b0;
      sat_r          <= 1'b0;
      bus.out_l      <= '0;
      bus.out_r      <= '0;
      bus.out_valid  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.stb_missed <= 1'b0;
    end else begin
      bus.stb_missed <= bus.sample_stb && state != IDLE;
      case (state)
        IDLE: if (bus.sample_stb) begin
          snap_l    <= bus.in_l;
          snap_r    <= bus.in_r;
          snap_vol  <= {bus.vol5, bus.vol4, bus.vol3, bus.vol2, bus.vol1};
          snap_swap <= bus.swap_channels;
          acc_l     <= '0;
          acc_r     <= '0;
          idx       <= '0;
          bus.busy  <= 1'b1;
          state     <= MAC;
        end
        MAC: begin
          if (idx < 4'd5) acc_l <= acc_l + prod;
          else acc_r <= acc_r + prod;
          idx <= idx + 4'd1;
          if (idx == 4'd9) state <= SAT;
        end
        SAT: begin
          bus.out_l     <= snap_swap ? cr[15:0] : cl[15:0];
          bus.out_r     <= snap_swap ? cl[15:0] : cr[15:0];
          sat_l         <= cl[16];
          sat_r         <= cr[16];
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        default: begin
          bus.out_valid <= 1'b0;
          sat_l         <= 1'b0;
          sat_r         <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_audio_mix_stage.sv
// tb_audio_mix_stage: randomized and directed checks of the mixer against an arithmetic model
module tb_audio_mix_stage;
  localparam int GS = 7;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  logic [79:0] il, ir;
  logic [39:0] vv;
  logic sw;
  audio_mix_if bus();
  audio_mix_stage #(.GAIN_SHIFT(GS)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic apply();
    bus.in_l = il;
    bus.in_r = ir;
    bus.vol1 = vv[7:0];
    bus.vol2 = vv[15:8];
    bus.vol3 = vv[23:16];
    bus.vol4 = vv[31:24];
    bus.vol5 = vv[39:32];
    bus.swap_channels = sw;
  endtask
  function automatic void model(output logic [15:0] el, output logic [15:0] er, output logic eo);
    int sl, sr, ql, qr, cl, cr;
    sl = 0;
    sr = 0;
    for (int n = 0; n < 5; n++) begin
      sl += int'($signed(il[16*n +: 16])) * int'(vv[8*n +: 8]);
      sr += int'($signed(ir[16*n +: 16])) * int'(vv[8*n +: 8]);
    end
    ql = sl >>> GS;
    qr = sr >>> GS;
    cl = ql > 32767 ? 32767 : (ql < -32768 ? -32768 : ql);
    cr = qr > 32767 ? 32767 : (qr < -32768 ? -32768 : qr);
    eo = (cl != ql) || (cr != qr);
    el = sw ? cr[15:0] : cl[15:0];
    er = sw ? cl[15:0] : cr[15:0];
  endfunction
  // Pulses sample_stb in the current cycle and returns in the out_valid cycle (or on timeout)
  task automatic do_frame(input logic scramble, output logic [15:0] ol, output logic [15:0] orr,
                          output logic ov, output int lat, output int missed, output int bcnt);
    bus.sample_stb = 1'b1;
    tick();
    bus.sample_stb = 1'b0;
    lat = 1;
    missed = 0;
    bcnt = 0;
    while (lat < 20) begin
      if (scramble) begin
        bus.in_l = 80'({$urandom, $urandom, $urandom});
        bus.in_r = 80'({$urandom, $urandom, $urandom});
        bus.vol1 = 8'($urandom);
        bus.vol3 = 8'($urandom);
        bus.swap_channels = ~bus.swap_channels;
      end
      missed += int'(bus.stb_missed);
      bcnt += int'(bus.busy);
      if (bus.out_valid) break;
      tick();
      lat++;
    end
    ol = bus.out_l;
    orr = bus.out_r;
    ov = bus.audio_overflow;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.sample_stb = 1'b1;
    tick();
    tick();
    bus.sample_stb = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_l !== 16'h0 || bus.out_r !== 16'h0) begin errs++; $display("FAIL reset_out got=%h/%h exp=0000/0000", bus.out_l, bus.out_r); end
    checks++; if (bus.audio_overflow !== 1'b0 || bus.stb_missed !== 1'b0) begin errs++; $display("FAIL reset_flags got=%b/%b exp=0/0", bus.audio_overflow, bus.stb_missed); end
    rst = 1'b0;
    tick();
  endtask
  task automatic run_directed(input string name, input logic [15:0] xl, input logic [15:0] xr, input logic xo);
    logic [15:0] ol, orr;
    logic ov;
    int lat, missed, bcnt;
    apply();
    do_frame(1'b0, ol, orr, ov, lat, missed, bcnt);
    checks++; if (lat != 12) begin errs++; $display("FAIL %s_latency got=%0d exp=12", name, lat); end
    checks++; if (bcnt != 12) begin errs++; $display("FAIL %s_busy got=%0d exp=12", name, bcnt); end
    checks++; if (ol !== xl || orr !== xr) begin errs++; $display("FAIL %s_out got=%h/%h exp=%h/%h", name, ol, orr, xl, xr); end
    checks++; if (ov !== xo) begin errs++; $display("FAIL %s_ovf got=%b exp=%b", name, ov, xo); end
    tick();
  endtask
  task automatic test_unity();
    il = '0; ir = '0; il[15:0] = 16'h1234; ir[15:0] = 16'hF000; vv = {5{8'h80}}; sw = 1'b0;
    run_directed("unity", 16'h1234, 16'hF000, 1'b0);
  endtask
  task automatic test_saturation();
    il = {5{16'h4000}}; ir = {5{16'hC000}}; vv = {5{8'h80}}; sw = 1'b0;
    run_directed("sat", 16'h7FFF, 16'h8000, 1'b1);
  endtask
  task automatic test_swap_volume();
    il = '0; ir = '0; il[47:32] = 16'h2000; vv = {5{8'h80}}; vv[23:16] = 8'h40; sw = 1'b1;
    run_directed("swap", 16'h0000, 16'h1000, 1'b0);
  endtask
  task automatic test_zero_max();
    il = {5{16'h7FFF}}; ir = {5{16'h8000}}; vv = '0; sw = 1'b0;
    run_directed("zero_gain", 16'h0000, 16'h0000, 1'b0);
    il = '0; ir = '0; il[15:0] = 16'h3FFF; vv = '0; vv[7:0] = 8'hFF;
    run_directed("max_gain", 16'h7F7E, 16'h0000, 1'b0);
  endtask
  task automatic test_missed_strobe();
    logic [15:0] el, er, ol, orr;
    logic eo, ov;
    int c, missed, lat, bcnt;
    il = 80'({$urandom, $urandom, $urandom}); ir = 80'({$urandom, $urandom, $urandom});
    vv = 40'({$urandom, $urandom}); sw = 1'b0;
    apply();
    model(el, er, eo);
    bus.sample_stb = 1'b1;
    tick();
    bus.sample_stb = 1'b0;
    c = 1;
    missed = 0;
    while (c < 20 && !bus.out_valid) begin
      missed += int'(bus.stb_missed);
      bus.sample_stb = (c == 5);
      if (c == 5) bus.vol1 = ~vv[7:0];
      tick();
      c++;
    end
    checks++; if (c != 12) begin errs++; $display("FAIL missed_latency got=%0d exp=12", c); end
    checks++; if (missed != 1) begin errs++; $display("FAIL missed_count got=%0d exp=1", missed); end
    checks++; if (bus.out_l !== el || bus.out_r !== er || bus.audio_overflow !== eo) begin
      errs++; $display("FAIL snapshot_out got=%h/%h/%b exp=%h/%h/%b", bus.out_l, bus.out_r, bus.audio_overflow, el, er, eo);
    end
    bus.sample_stb = 1'b1;
    tick();
    bus.sample_stb = 1'b0;
    checks++; if (bus.stb_missed !== 1'b1 || bus.busy !== 1'b0) begin
      errs++; $display("FAIL done_stb got missed=%b busy=%b exp missed=1 busy=0", bus.stb_missed, bus.busy);
    end
    il = 80'({$urandom, $urandom, $urandom}); vv = 40'({$urandom, $urandom}); sw = 1'b1;
    apply();
    model(el, er, eo);
    do_frame(1'b0, ol, orr, ov, lat, missed, bcnt);
    checks++; if (lat != 12 || ol !== el || orr !== er || ov !== eo) begin
      errs++; $display("FAIL idle_stb got lat=%0d out=%h/%h/%b exp lat=12 out=%h/%h/%b", lat, ol, orr, ov, el, er, eo);
    end
    checks++; if (missed != 0) begin errs++; $display("FAIL idle_stb_missed got=%0d exp=0", missed); end
    tick();
  endtask
  task automatic test_reset_mid();
    int nvalid;
    il = '0; ir = '0; il[15:0] = 16'h0100; ir[15:0] = 16'h0200; vv = {5{8'h80}}; sw = 1'b0;
    apply();
    bus.sample_stb = 1'b1;
    tick();
    bus.sample_stb = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.out_l !== 16'h0 || bus.out_r !== 16'h0) begin
      errs++; $display("FAIL midrst_state got busy=%b out=%h/%h exp busy=0 out=0000/0000", bus.busy, bus.out_l, bus.out_r);
    end
    nvalid = 0;
    for (int i = 0; i < 15; i++) begin
      nvalid += int'(bus.out_valid);
      tick();
    end
    checks++; if (nvalid != 0) begin errs++; $display("FAIL midrst_valid got=%0d exp=0", nvalid); end
    rst = 1'b1;
    bus.sample_stb = 1'b1;
    tick();
    rst = 1'b0;
    bus.sample_stb = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rst_priority got busy=%b exp=0", bus.busy); end
    run_directed("after_rst", 16'h0100, 16'h0200, 1'b0);
  endtask
  task automatic test_random();
    logic [15:0] el, er, ol, orr;
    logic eo, ov;
    int lat, missed, bcnt;
    for (int k = 0; k < 40; k++) begin
      il = 80'({$urandom, $urandom, $urandom});
      ir = 80'({$urandom, $urandom, $urandom});
      vv = 40'({$urandom, $urandom});
      if (k % 4 == 0) vv = {5{8'h80}};
      if (k % 5 == 1) begin il = il >> 1; ir = ir >> 3; end
      sw = 1'($urandom);
      apply();
      model(el, er, eo);
      do_frame(1'b1, ol, orr, ov, lat, missed, bcnt);
      checks++; if (lat != 12 || bcnt != 12) begin errs++; $display("FAIL rnd%0d_timing got lat=%0d busy=%0d exp 12/12", k, lat, bcnt); end
      checks++; if (ol !== el || orr !== er) begin errs++; $display("FAIL rnd%0d_out got=%h/%h exp=%h/%h", k, ol, orr, el, er); end
      checks++; if (ov !== eo) begin errs++; $display("FAIL rnd%0d_ovf got=%b exp=%b", k, ov, eo); end
      tick();
      checks++; if (bus.out_valid !== 1'b0 || bus.audio_overflow !== 1'b0 || bus.out_l !== el || bus.out_r !== er) begin
        errs++; $display("FAIL rnd%0d_hold got v=%b o=%b out=%h/%h exp v=0 o=0 out=%h/%h", k, bus.out_valid, bus.audio_overflow, bus.out_l, bus.out_r, el, er);
      end
    end
  endtask
  initial begin
    bus.sample_stb = 1'b0;
    il = '0; ir = '0; vv = '0; sw = 1'b0;
    apply();
    test_reset();
    test_unity();
    test_saturation();
    test_swap_volume();
    test_zero_max();
    test_missed_strobe();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
